piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out frame serializer with stall, bit-order select and back-to-back loads.
// Optional trailing parity bit is compiled in with `define SER_PARITY_EN.
module piso_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  load,
    input  logic                  msb_first,
    input  logic                  ser_en,
`ifdef SER_PARITY_EN
    input  logic                  par_typ,
`endif
    output logic                  ser_data,
    output logic                  ser_done,
    output logic                  ready,
    output logic                  busy
);

`ifdef SER_PARITY_EN
    localparam int unsigned FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = DATA_WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] sreg, sreg_nxt;
    logic                  order, order_nxt;
    logic                  ser_data_nxt;
    logic                  ser_done_nxt;
    logic                  ready_nxt;
    logic                  busy_nxt;
    logic                  capture;
    logic                  out_bit;
`ifdef SER_PARITY_EN
    logic                  par_bit, par_bit_nxt;
`endif

    // Bit presented at the emitting end of the frame for the current count.
    always_comb begin
        out_bit = order ? sreg[DATA_WIDTH-1] : sreg[0];
`ifdef SER_PARITY_EN
        if (cnt == CNT_W'(DATA_WIDTH)) begin
            out_bit = par_bit;
        end
`endif
    end

    // State register and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            sreg     <= '0;
            order    <= 1'b0;
            ser_data <= 1'b0;
            ser_done <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
`ifdef SER_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sreg     <= sreg_nxt;
            order    <= order_nxt;
            ser_data <= ser_data_nxt;
            ser_done <= ser_done_nxt;
            ready    <= ready_nxt;
            busy     <= busy_nxt;
`ifdef SER_PARITY_EN
            par_bit  <= par_bit_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sreg_nxt     = sreg;
        order_nxt    = order;
        ser_data_nxt = ser_data;
        capture      = 1'b0;
`ifdef SER_PARITY_EN
        par_bit_nxt  = par_bit;
`endif

        case (state)
            IDLE: begin
                ser_data_nxt = 1'b0;
                capture      = load;
            end
            SHIFT: begin
                if (ser_en) begin
                    ser_data_nxt = out_bit;
                    sreg_nxt     = order ? (sreg << 1) : (sreg >> 1);
                    cnt_nxt      = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (load) begin
                    capture = 1'b1;
                end else begin
                    state_nxt    = IDLE;
                    ser_data_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                ser_data_nxt = 1'b0;
            end
        endcase

        // Accepted load: ready is high in both IDLE and DONE.
        if (capture) begin
            sreg_nxt  = P_DATA;
            order_nxt = msb_first;
            cnt_nxt   = '0;
            state_nxt = SHIFT;
`ifdef SER_PARITY_EN
            par_bit_nxt = (^P_DATA) ^ par_typ;
`endif
        end

        ready_nxt    = (state_nxt != SHIFT);
        busy_nxt     = (state_nxt == SHIFT);
        ser_done_nxt = (state_nxt == DONE);
    end

endmodule
